// File: rtl/mxv_sequencer.sv
// Control FSM for one N x N matrix by N-vector product: steps operand indices,
// drives the accumulator enable/clear and writes one output element per row.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// CLEAR | clear + enable accumulator, col reset to 0
// MAC   | one accumulate per non-stalled cycle, col steps 0..N-1
// WRITE | accumulator value written to output vector at row
// DONE  | one-cycle completion pulse
module mxv_sequencer #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] row_idx,
  output logic [IW-1:0] col_idx,
  output logic          mac_enb,
  output logic          acc_clr,
  output logic          out_wr,
  output logic [IW-1:0] out_idx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t state;
  logic   mac_phase;

  // Only the accumulate enable follows stall within the same cycle; all other
  // outputs are registered alongside the state they belong to.
  assign mac_enb = acc_clr | (mac_phase & ~stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_idx   <= '0;
      col_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc_clr   <= 1'b0;
      out_wr    <= 1'b0;
      out_idx   <= '0;
      mac_phase <= 1'b0;
    end else begin
      done      <= 1'b0;
      acc_clr   <= 1'b0;
      out_wr    <= 1'b0;
      out_idx   <= '0;
      mac_phase <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            row_idx <= '0;
            col_idx <= '0;
            busy    <= 1'b1;
            acc_clr <= 1'b1;
          end
        end
        CLEAR: begin
          state     <= MAC;
          col_idx   <= '0;
          mac_phase <= 1'b1;
        end
        MAC: begin
          if (stall) begin
            mac_phase <= 1'b1;
          end else if (col_idx == LAST) begin
            state   <= WRITE;
            out_wr  <= 1'b1;
            out_idx <= row_idx;
          end else begin
            col_idx   <= col_idx + 1'b1;
            mac_phase <= 1'b1;
          end
        end
        WRITE: begin
          if (row_idx == LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= CLEAR;
            row_idx <= row_idx + 1'b1;
            col_idx <= '0;
            acc_clr <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          row_idx <= '0;
          col_idx <= '0;
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          row_idx <= '0;
          col_idx <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mxv_sequencer.sv
// Scoreboard bench for mxv_sequencer: N=4 and N=1 instances, directed cycle-exact
// expectations for clear / write / done events plus in-cycle index checks.
module tb_mxv_sequencer;

  typedef struct {
    int kind;  // 0 clear, 1 write, 2 done
    int cyc;
    int idx;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  ev_t q4[$];
  ev_t q1[$];
  int  mac_cnt4 = 0;
  int  col_log4[$];

  logic       rst4, start4, stall4;
  logic       busy4, done4, mac4, clr4, wr4;
  logic [1:0] row4, col4, oidx4;

  logic       rst1, start1, stall1;
  logic       busy1, done1, mac1, clr1, wr1;
  logic [0:0] row1, col1, oidx1;

  mxv_sequencer #(.N(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .stall(stall4),
    .busy(busy4), .done(done4), .row_idx(row4), .col_idx(col4),
    .mac_enb(mac4), .acc_clr(clr4), .out_wr(wr4), .out_idx(oidx4)
  );

  mxv_sequencer #(.N(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .stall(stall1),
    .busy(busy1), .done(done1), .row_idx(row1), .col_idx(col1),
    .mac_enb(mac1), .acc_clr(clr1), .out_wr(wr1), .out_idx(oidx1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input int k, input int c, input int i);
    ev_t e;
    e.kind = k; e.cyc = c; e.idx = i;
    q4.push_back(e);
  endtask

  task automatic push1(input int k, input int c, input int i);
    ev_t e;
    e.kind = k; e.cyc = c; e.idx = i;
    q1.push_back(e);
  endtask

  // Standard unstalled N=4 product accepted in cycle s.
  task automatic push_product4(input int s);
    for (int r = 0; r < 4; r++) begin
      push4(0, s + 1 + 6 * r, 0);
      push4(1, s + 6 + 6 * r, r);
    end
    push4(2, s + 25, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (clr4 || wr4 || done4) begin
        int k;
        k = done4 ? 2 : (wr4 ? 1 : 0);
        if (q4.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event4 at cycle %0d: kind=%0d, none expected", cyc, k);
        end else begin
          ev_t e;
          e = q4.pop_front();
          chk("ev4_kind", k, e.kind);
          chk("ev4_cycle", cyc, e.cyc);
          if (k == 1) chk("ev4_out_idx", int'(oidx4), e.idx);
        end
        if (clr4) chk("ev4_clr_with_enb", int'(mac4), 1);
      end
      if (mac4 && !clr4) begin
        mac_cnt4++;
        col_log4.push_back(int'(col4));
      end
      if (clr1 || wr1 || done1) begin
        int k;
        k = done1 ? 2 : (wr1 ? 1 : 0);
        if (q1.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event1 at cycle %0d: kind=%0d, none expected", cyc, k);
        end else begin
          ev_t e;
          e = q1.pop_front();
          chk("ev1_kind", k, e.kind);
          chk("ev1_cycle", cyc, e.cyc);
          if (k == 1) chk("ev1_out_idx", int'(oidx1), e.idx);
        end
      end
    end
  end

  initial begin
    int t0;
    rst4 = 1'b1; start4 = 1'b0; stall4 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; stall1 = 1'b0;
    tick(); tick(); tick();
    rst4 = 1'b0; rst1 = 1'b0;
    #2;
    chk("rst_busy", int'(busy4), 0);
    chk("rst_done", int'(done4), 0);
    chk("rst_mac_enb", int'(mac4), 0);
    chk("rst_acc_clr", int'(clr4), 0);
    chk("rst_out_wr", int'(wr4), 0);
    chk("rst_row", int'(row4), 0);
    chk("rst_col", int'(col4), 0);
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      #2;
      chk("idle_busy", int'(busy4), 0);
    end
    tick();

    // single unstalled product
    t0 = cyc; mac_cnt4 = 0; col_log4.delete();
    push_product4(t0);
    for (int r = 0; r <= 27; r++) begin
      start4 = (r == 0);
      #2;
      if (r == 26) chk("single_idle_busy", int'(busy4), 0);
      tick();
    end
    start4 = 1'b0;
    chk("single_mac_count", mac_cnt4, 16);
    for (int i = 0; i < 16; i++) begin
      if (i < col_log4.size()) chk("single_col_seq", col_log4[i], i % 4);
    end
    chk("single_queue_empty", q4.size(), 0);

    // 3-cycle stall at row 1 col 2, plus a stall during the row 2 clear
    t0 = cyc; mac_cnt4 = 0;
    push4(0, t0 + 1, 0);  push4(1, t0 + 6, 0);
    push4(0, t0 + 7, 0);  push4(1, t0 + 15, 1);
    push4(0, t0 + 16, 0); push4(1, t0 + 21, 2);
    push4(0, t0 + 22, 0); push4(1, t0 + 27, 3);
    push4(2, t0 + 28, 0);
    for (int r = 0; r <= 30; r++) begin
      start4 = (r == 0);
      stall4 = (r >= 10 && r <= 12) || (r == 16);
      #2;
      if (r >= 10 && r <= 12) begin
        chk("stall_col_hold", int'(col4), 2);
        chk("stall_row", int'(row4), 1);
        chk("stall_mac_enb", int'(mac4), 0);
      end
      if (r == 16) chk("stall_clear_enb", int'(mac4), 1);
      tick();
    end
    start4 = 1'b0; stall4 = 1'b0;
    chk("stall_mac_count", mac_cnt4, 16);
    chk("stall_queue_empty", q4.size(), 0);

    // start ignored while busy and in DONE, accepted again in the next IDLE
    t0 = cyc;
    push_product4(t0);
    push_product4(t0 + 26);
    for (int r = 0; r <= 53; r++) begin
      start4 = (r == 0) || (r == 5) || (r == 25) || (r == 26);
      tick();
    end
    start4 = 1'b0;
    chk("restart_queue_empty", q4.size(), 0);

    // reset mid-product, then a fresh product
    t0 = cyc;
    push4(0, t0 + 1, 0); push4(1, t0 + 6, 0); push4(0, t0 + 7, 0);
    push_product4(t0 + 12);
    for (int r = 0; r <= 39; r++) begin
      start4 = (r == 0) || (r == 12);
      rst4 = (r == 10);
      #2;
      if (r == 11) begin
        chk("midrst_busy", int'(busy4), 0);
        chk("midrst_mac_enb", int'(mac4), 0);
        chk("midrst_col", int'(col4), 0);
      end
      tick();
    end
    start4 = 1'b0; rst4 = 1'b0;
    chk("midrst_queue_empty", q4.size(), 0);

    // N=1 instance
    t0 = cyc;
    push1(0, t0 + 1, 0); push1(1, t0 + 3, 0); push1(2, t0 + 4, 0);
    for (int r = 0; r <= 6; r++) begin
      start1 = (r == 0);
      #2;
      if (r == 2) begin
        chk("n1_mac_enb", int'(mac1), 1);
        chk("n1_mac_clr", int'(clr1), 0);
        chk("n1_mac_busy", int'(busy1), 1);
      end
      if (r == 5) chk("n1_idle_busy", int'(busy1), 0);
      tick();
    end
    start1 = 1'b0;
    chk("n1_queue_empty", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
